// File: rtl/spi_master_pkg.sv
// spi_defs: shared constants for the SPI mode-0 initiator.
//   - 3-bit FSM state encodings (kept as plain localparams for legacy tools)
//   - default frame width / clock divider
//   - mode-0 clock polarity / phase
package spi_defs;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_CLKDIV = 4;

  // Mode 0: SCLK idles low, data sampled on the rising edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LEAD     = 3'd1;
  localparam logic [2:0] S_HIGH     = 3'd2;
  localparam logic [2:0] S_LOW      = 3'd3;
  localparam logic [2:0] S_TRAIL    = 3'd4;
  localparam logic [2:0] S_SELECTED = 3'd5;

endpackage

// File: rtl/spi_master_clkgen.sv
// spi_clkgen: SCLK half-period divider.
//   clk, reset : system clock, synchronous active-high reset
//   enable     : count while high
//   clear      : force the count back to 0 (frame accept)
//   tick       : high for the cycle in which the count sits at CLKDIV-1
module spi_clkgen #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = enable && (r_cnt == LAST);
  assign tick   = w_tick;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator, one WIDTH-bit frame per start, MSB first.
//   clk, reset       : system clock, synchronous active-high reset
//   start            : frame request (only looked at while busy=0)
//   keepSelected     : captured with start; 1 keeps cs low after the frame
//   txData / rxData  : frame out / last frame in (rxData changes only at done)
//   busy, done       : busy from accept until done; done is a 1-cycle pulse
//   sclk, cs, mosi   : SPI pins driven by us; miso sampled on sclk rise
module spi_master
  import spi_defs::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CLKDIV = DEF_CLKDIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             keepSelected,
  input  logic [WIDTH-1:0] txData,
  output logic [WIDTH-1:0] rxData,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             cs,
  output logic             mosi,
  input  logic             miso
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic [2:0]       r_state;
  logic [BW-1:0]    r_bitCount;
  // MSB goes straight to mosi on accept, so only the remaining bits are kept.
  logic [WIDTH-2:0] r_txShift;
  logic [WIDTH-1:0] r_rxShift;
  logic [WIDTH-1:0] r_rxData;
  logic             r_keep, r_busy, r_done, r_sclk, r_cs, r_mosi;

  logic w_tick, w_accept, w_run;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_SELECTED));
  assign w_run    = (r_state == S_LEAD) || (r_state == S_HIGH) ||
                    (r_state == S_LOW)  || (r_state == S_TRAIL);

  spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .clk    (clk),
    .reset  (reset),
    .enable (w_run),
    .clear  (w_accept),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bitCount <= '0;
      r_txShift  <= '0;
      r_rxShift  <= '0;
      r_rxData   <= '0;
      r_keep     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sclk     <= CPOL;
      r_cs       <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_SELECTED: begin
          if (start) begin
            r_txShift  <= txData[WIDTH-2:0];
            r_mosi     <= txData[WIDTH-1];
            r_cs       <= 1'b0;  // already 0 from SELECTED, so no glitch
            r_busy     <= 1'b1;
            r_bitCount <= '0;
            r_keep     <= keepSelected;
            r_state    <= S_LEAD;
          end
        end
        S_LEAD, S_LOW: begin
          if (w_tick) begin
            r_sclk    <= ~CPOL;
            r_rxShift <= {r_rxShift[WIDTH-2:0], miso};
            r_state   <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (w_tick) begin
            r_sclk <= CPOL;
            if (r_bitCount == LAST_BIT) begin
              r_state <= S_TRAIL;
            end else begin
              // Next bit is launched on the falling edge, half a period
              // before the rising edge that samples it.
              r_bitCount <= r_bitCount + 1'b1;
              r_mosi     <= r_txShift[WIDTH-2];
              r_txShift  <= r_txShift << 1;
              r_state    <= S_LOW;
            end
          end
        end
        S_TRAIL: begin
          if (w_tick) begin
            r_done   <= 1'b1;
            r_rxData <= r_rxShift;
            r_busy   <= 1'b0;
            r_mosi   <= 1'b0;
            if (r_keep) begin
              r_state <= S_SELECTED;
            end else begin
              r_cs    <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rxData = r_rxData;
  assign busy   = r_busy;
  assign done   = r_done;
  assign sclk   = r_sclk;
  assign cs     = r_cs;
  assign mosi   = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int LAT = (2 * W + 1) * DIV;

  logic         clk = 1'b0;
  logic         reset, start, keepSelected, miso;
  logic [W-1:0] txData, rxData;
  logic         busy, done, sclk, cs, mosi;

  spi_master #(.WIDTH(W), .CLKDIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .keepSelected(keepSelected),
    .txData(txData), .rxData(rxData), .busy(busy), .done(done),
    .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // miso source: 0 = loopback from mosi, 1 = mode-0 slave model, 2 = constant 1
  int           mode = 0;
  logic [W-1:0] slave_pre = '0;
  logic [W-1:0] slave_tx = '0;
  logic [W-1:0] slave_rx = '0;
  int           rises = 0;
  int           mosi_viol = 0;
  logic         p_sclk = 1'b0, p_mosi = 1'b0;

  assign miso = (mode == 0) ? mosi : (mode == 1) ? slave_tx[W-1] : 1'b1;

  // Pin-level observer and mode-0 slave: sample mosi on sclk rise, shift its
  // own data out on sclk fall, reload while deselected.
  always @(negedge clk) begin
    if (cs) slave_tx = slave_pre;
    if (sclk && !p_sclk) begin
      rises++;
      slave_rx = {slave_rx[W-2:0], mosi};
    end
    if (!sclk && p_sclk) slave_tx = {slave_tx[W-2:0], 1'b0};
    if (sclk && p_sclk && (mosi !== p_mosi)) mosi_viol++;
    p_sclk = sclk;
    p_mosi = mosi;
  end

  logic [W-1:0] prev_rx = '0;

  // Runs one frame from the current negedge (busy must be 0).
  // disturb: 0 none, 1 extra start pulses at cycles 5 and 30, 2 reset at cycle 25.
  task automatic frame(input logic [W-1:0] tx, input logic kp, input int disturb,
                       output logic [W-1:0] rx, output int lat, output int cs_hi);
    int n;
    rx = '0; lat = -1; cs_hi = 0;
    start = 1'b1; txData = tx; keepSelected = kp;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; txData = W'($urandom); keepSelected = 1'($urandom);
    n = 0;
    while (n < 4 * LAT) begin
      @(posedge clk); n++;
      @(negedge clk);
      start = (disturb == 1) && (n == 5 || n == 30);
      if (start) begin txData = W'($urandom); keepSelected = 1'b1; end
      if (n == 40) chk("rx_held", rxData, prev_rx);
      if (disturb == 2 && n == 25) begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_cs", cs, 1); chk("abort_sclk", sclk, 0);
        chk("abort_busy", busy, 0); chk("abort_rx", rxData, 0);
        chk("abort_done", done, 0);
        reset = 1'b0;
        prev_rx = '0;
        lat = 0;
        return;
      end
      if (done) begin
        rx = rxData; lat = n; prev_rx = rxData;
        return;
      end
      if (cs) cs_hi++;
    end
    chk("timeout", 0, 1);
  endtask

  logic [W-1:0] rx;
  int lat, cs_hi, cs_hi2, r0, v0, dn;

  initial begin
    reset = 1'b1; start = 1'b0; keepSelected = 1'b0; txData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sclk", sclk, 0); chk("rst_cs", cs, 1); chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rx", rxData, 0);
    reset = 1'b0;
    @(negedge clk);

    // Loopback A5
    mode = 0; r0 = rises;
    frame(8'hA5, 1'b0, 0, rx, lat, cs_hi);
    chk("lb_rx", rx, 8'hA5); chk("lb_lat", lat, LAT);
    chk("lb_rises", rises - r0, W); chk("lb_cs_low", cs_hi, 0);
    chk("lb_cs_end", cs, 1); chk("lb_busy_end", busy, 0);
    repeat (3) @(negedge clk);

    // Slave model preloaded with AB, master sends 80
    mode = 1; slave_pre = 8'hAB; r0 = rises; v0 = mosi_viol;
    @(negedge clk);
    frame(8'h80, 1'b0, 0, rx, lat, cs_hi);
    chk("sl_rx", rx, 8'hAB); chk("sl_slave_rx", slave_rx, 8'h80);
    chk("sl_mosi_stable", mosi_viol - v0, 0); chk("sl_rises", rises - r0, W);
    repeat (3) @(negedge clk);

    // Held selection across two frames, miso=1
    mode = 2; r0 = rises;
    frame(8'h81, 1'b1, 0, rx, lat, cs_hi);
    chk("k1_rx", rx, 8'hFF); chk("k1_cs_held", cs, 0); chk("k1_busy", busy, 0);
    frame(8'h3C, 1'b0, 0, rx, lat, cs_hi2);
    chk("k2_rx", rx, 8'hFF); chk("k2_lat", lat, LAT);
    chk("k_cs_low", cs_hi + cs_hi2, 0); chk("k_rises", rises - r0, 2 * W);
    chk("k2_cs_end", cs, 1);
    repeat (3) @(negedge clk);

    // Start pulses while busy are ignored
    mode = 0; r0 = rises;
    frame(8'h0F, 1'b0, 1, rx, lat, cs_hi);
    chk("ign_rx", rx, 8'h0F); chk("ign_lat", lat, LAT);
    dn = 0;
    repeat (2 * LAT) begin @(negedge clk); if (done) dn++; end
    chk("ign_extra_done", dn, 0); chk("ign_rises", rises - r0, W);
    chk("ign_cs", cs, 1);

    // Reset mid-frame, then a normal frame
    frame(8'hC3, 1'b0, 2, rx, lat, cs_hi);
    dn = 0;
    repeat (DIV * 4) begin @(negedge clk); if (done) dn++; end
    chk("abort_no_done", dn, 0);
    frame(8'h5A, 1'b0, 0, rx, lat, cs_hi);
    chk("post_rst_rx", rx, 8'h5A); chk("post_rst_lat", lat, LAT);

    // Randomized frames against the reference: loopback returns tx,
    // slave returns its preload and captures tx; always W rises and LAT cycles.
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] t, p;
      logic k;
      t = W'($urandom); p = W'($urandom); k = 1'($urandom);
      mode = int'($urandom_range(0, 1));
      slave_pre = p;
      repeat (int'($urandom_range(1, 4))) @(negedge clk);
      r0 = rises; v0 = mosi_viol;
      frame(t, k, 0, rx, lat, cs_hi);
      chk("rnd_rx", rx, (mode == 0) ? t : p);
      chk("rnd_lat", lat, LAT);
      chk("rnd_rises", rises - r0, W);
      chk("rnd_mosi_stable", mosi_viol - v0, 0);
      chk("rnd_cs_end", cs, !k);
      if (mode == 1) chk("rnd_slave_rx", slave_rx, t);
      // A held selection must stay low until the next frame; close it with a
      // deselecting frame so the slave reloads its preload afterwards.
      if (k) begin
        repeat (5) @(negedge clk);
        chk("rnd_sel_idle", cs, 0);
        mode = 0;
        frame(t ^ 8'hFF, 1'b0, 0, rx, lat, cs_hi);
        chk("rnd_close_rx", rx, t ^ 8'hFF);
        chk("rnd_close_cs", cs, 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Mode-0 SPI initiator that drives SCLK, CS and MOSI, and samples MISO. It is the other end of the peripheral-side shift-register datapath.
- Transfers one WIDTH-bit frame per start request, MSB first.
- With keepSelected set, CS stays asserted across frames so multi-byte transactions (address byte, then data byte) reach the SPI memory peripheral intact.
- Sits between the bench/host logic and the SPI pins.

Parameters:
- WIDTH, 8, bits per frame.
- CLKDIV, 4, clk cycles per SCLK half-period; legal values are 2 or more.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame request; sampled only when busy=0.
- keepSelected  input  1  sampled with start; 1 = hold CS low after this frame.
- txData  input  WIDTH  frame to send; captured on the accepting edge.
- rxData  output  WIDTH  last received frame; valid when done=1, held until the next done.
- busy  output  1  high from the accepting edge until done.
- done  output  1  one-cycle pulse at the end of each frame.
- sclk  output  1  SPI clock; idles low.
- cs  output  1  active-low chip select.
- mosi  output  1  serial data out, MSB first.
- miso  input  1  serial data in.

Behaviour:
- Reset values: sclk=0, cs=1, mosi=0, busy=0, done=0, rxData=0, state=IDLE, divider=0, bitCount=0.
- Reset asserted mid-frame aborts the frame on that edge: cs=1, sclk=0, no done pulse.
- Divider:
  - Counts 0..CLKDIV-1 and asserts tick when it reaches CLKDIV-1.
  - Is cleared on frame accept.
  - Runs only in LEAD/HIGH/LOW/TRAIL.
- States: IDLE, LEAD, HIGH, LOW, TRAIL, SELECTED.
- IDLE or SELECTED, start=1, accepting edge:
  - txShift<=txData; mosi<=txData[WIDTH-1]; cs<=0; busy<=1; bitCount<=0; keep<=keepSelected.
  - Go to LEAD.
  - From SELECTED, cs is already 0 and shows no glitch.
- LEAD, tick: sclk<=1; rxShift<={rxShift[WIDTH-2:0],miso}; go to HIGH.
- HIGH, tick:
  - sclk<=0.
  - If bitCount==WIDTH-1, go to TRAIL.
  - Otherwise bitCount++, mosi<=next bit of txShift, go to LOW.
- LOW, tick: sclk<=1; sample miso into rxShift as in LEAD; go to HIGH.
- TRAIL, tick:
  - done<=1 for one cycle; rxData<=rxShift; busy<=0; mosi<=0.
  - If keep=1: cs stays 0, go to SELECTED.
  - Otherwise: cs<=1, go to IDLE.
- Frame length:
  - Exactly WIDTH sclk rising edges per frame.
  - MOSI changes only while sclk=0, so it is stable at every rising edge.
  - MISO is sampled on each rising edge.
- Latency:
  - done is high during the cycle following the (2*WIDTH+1)*CLKDIV-th clk edge after the accepting edge.
  - Defaults give 68 cycles.
- start while busy=1 is ignored; txData and keepSelected are not re-sampled.
- start may be accepted in the same cycle done is high, because busy is already 0; this gives back-to-back frames.
- SELECTED with no start: cs remains 0 indefinitely. The host ends the transaction by issuing its last frame with keepSelected=0.
- rxData updates only at done, never mid-frame.

Decomposition:
- Shared package spi_defs:
  - State encoding constants (3-bit): IDLE, LEAD, HIGH, LOW, TRAIL, SELECTED.
  - Default WIDTH=8 and CLKDIV=4.
  - SPI mode-0 polarity constants: CPOL=0, CPHA=0.
- One sub-module, spi_clkgen: half-period divider with inputs clk, reset, enable, clear and output tick. Parameter CLKDIV.
- FSM and shift registers stay in spi_master.

Test Plan:
- Loopback (miso tied to mosi), txData=8'hA5, keepSelected=0:
  - rxData=8'hA5 with done exactly 68 cycles after accept.
  - 8 sclk rising edges.
  - cs low for the whole frame, then 1.
- Bench mode-0 slave model preloaded with 8'b10101011, master sends 8'h80:
  - Master rxData=8'hAB.
  - Slave receives 8'h80.
  - MOSI is never seen changing while sclk=1.
- Two frames 8'h81 (keepSelected=1) then 8'h3C (keepSelected=0), miso=1:
  - cs stays 0 continuously across both frames.
  - 16 rising edges total.
  - Two done pulses, each with rxData=8'hFF.
  - cs=1 after the second done.
- start pulsed again at cycles 5 and 30 of a frame sending 8'h0F:
  - Pulses are ignored.
  - Single done pulse; loopback rxData=8'h0F.
- reset asserted at cycle 25 of a frame:
  - On the next edge: cs=1, sclk=0, busy=0, rxData=0, and no done pulse.
  - A subsequent start with 8'h5A completes normally, giving loopback rxData=8'h5A.
